ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port 1024x32 synchronous data RAM between two requesters: port A (instruction fetch) and port B (load/store unit).
- Each requester uses a req/ack handshake. The block arbitrates between them, drives the RAM's clk-domain control inputs from registers, and returns read data on the granted port.
- It sits between the core's fetch/MEM stages and the RAM, and is the RAM's only driver.

Parameters:
- ADDR_W, 10, RAM address width (word address).
- DATA_W, 32, data width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with port A winning.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A write enable; stable while a_req is high.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle completion pulse for port A.
- a_rdata  out  DATA_W  port A read data; valid only when a_ack is high.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- ram_we  out  1  to RAM we (registered).
- ram_addr  out  ADDR_W  to RAM addr (registered).
- ram_din  out  DATA_W  to RAM din (registered).
- ram_dout  in  DATA_W  from RAM dout. The RAM captures dout on the posedge where we=0 and holds it otherwise.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, a_ack=b_ack=0, busy=0, last_grant=B. Because last_grant resets to B, port A wins the first tie in round-robin mode.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high at the posedge:
  - choose a winner;
  - load ram_we/ram_addr/ram_din from the winner's we/addr/wdata;
  - record the winner in sel and its we in op_we;
  - go to ACCESS.
  - If no req is high, stay in IDLE with ram_we=0.
- ACCESS: RAM inputs are stable. At this posedge the RAM performs the write, or latches read data into dout. Clear ram_we to 0, then go to DONE.
- DONE: assert ack on the sel port for exactly this cycle, then return to IDLE.
  - Read (op_we=0): rdata of the sel port = ram_dout.
  - Write (op_we=1): rdata = 0.
  - Non-selected port: ack=0, rdata=0.
- rdata is a combinational mux from ram_dout, qualified by state==DONE, sel and op_we. There is no extra register.
- Latency: req seen in cycle 0, ack in cycle 2. Throughput is one access per 3 cycles.
- Handshake rules:
  - The requester keeps req, we, addr and wdata stable from assertion until the cycle ack is high.
  - It deasserts req or changes its request at the posedge where ack is sampled.
  - A req still high in the cycle after ack is a new request.
  - Inputs of the non-selected port are ignored while busy; that port's req simply waits.
- Arbitration:
  - ARB_MODE=0: on a tie, grant the port that is not last_grant; a single requester always wins. last_grant updates on every grant.
  - ARB_MODE=1: A wins every tie. B can starve; this is accepted by design.
- Simultaneous events:
  - A new req arriving while in ACCESS or DONE is not sampled until IDLE.
  - A req dropped mid-transaction (protocol violation) does not abort it: the access completes and ack still pulses.
- Reset mid-operation: takes effect at the next posedge.
  - ram_we drops to 0 and the FSM goes to IDLE; no ack is generated.
  - The interrupted write may or may not have reached the RAM. It is complete only if ACCESS had already passed a posedge.
- Address wrap: none. Addresses pass through unchanged, and all ADDR_W-bit values are legal.

Decomposition:
- Package ram_arb_pkg holds:
  - the state encoding IDLE/ACCESS/DONE as a 2-bit enum;
  - PORT_A=0, PORT_B=1;
  - ARB_RR=0, ARB_FIXED=1.
- Sub-module rr_arb2: combinational 2-input winner select. Inputs are req_a, req_b, last_grant and mode; outputs are gnt (1 bit) and valid. The last_grant register stays in ram_arbiter.

Test Plan:
- Port A only, write 0xDEADBEEF to addr 5, then read addr 5 → ram_we=1 during ACCESS; a_ack in cycle 2 of each transaction; the read returns a_rdata=0xDEADBEEF; b_ack never asserts.
- Port B only, read addr 1023 after preloading 0x12345678 via B → b_rdata=0x12345678 in cycle 2; a_rdata=0 throughout.
- A and B both request continuously, ARB_MODE=0, after reset → grant order A,B,A,B; acks spaced 3 cycles apart; each port receives data from its own address (A reads addr 3 = 0x33, B reads addr 4 = 0x44).
- Same stimulus with ARB_MODE=1 → A is granted every time; b_ack stays 0 while a_req is held high.
- Write of 0xFFFFFFFF to addr 9 via B, then an immediate read of addr 9 via A → a_ack with a_rdata=0xFFFFFFFF; the write's b_rdata=0 during its ack.
- rst pulsed for 1 cycle while in ACCESS of a read → no ack; busy=0 and ram_we=0 the next cycle; the still-held req is re-granted and acked 3 cycles after rst falls.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester ports A/B, RAM-side control and status bundled for the arbiter.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
    output a_ack, a_rdata, b_ack, b_rdata, ram_we, ram_addr, ram_din, busy
  );

  // Requesters plus RAM side.
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
    input  a_ack, a_rdata, b_ack, b_rdata, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input winner select; fixed mode favours A, otherwise the port not granted last wins a tie.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  input  logic mode,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req_a | req_b;
    gnt   = PORT_A;
    if (req_a && req_b) begin
      gnt = mode ? PORT_A : ~last_grant;
    end else if (req_b) begin
      gnt = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between fetch (A) and load/store (B); 3 cycles per access.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              op_we_q, op_we_d;
  logic              last_grant_q, last_grant_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  logic arb_gnt, arb_valid;

  rr_arb2 u_rr_arb2 (
    .req_a      (bus.a_req),
    .req_b      (bus.b_req),
    .last_grant (last_grant_q),
    .mode       (ARB_MODE == ARB_FIXED),
    .gnt        (arb_gnt),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    op_we_d      = op_we_q;
    last_grant_d = last_grant_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    unique case (state_q)
      StIdle: begin
        ram_we_d = 1'b0;
        if (arb_valid) begin
          sel_d        = arb_gnt;
          last_grant_d = arb_gnt;
          if (arb_gnt == PORT_A) begin
            ram_we_d   = bus.a_we;
            ram_addr_d = bus.a_addr;
            ram_din_d  = bus.a_wdata;
          end else begin
            ram_we_d   = bus.b_we;
            ram_addr_d = bus.b_addr;
            ram_din_d  = bus.b_wdata;
          end
          op_we_d = ram_we_d;
          state_d = StAccess;
        end
      end
      StAccess: begin
        ram_we_d = 1'b0;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= PORT_A;
      op_we_q      <= 1'b0;
      last_grant_q <= PORT_B;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      op_we_q      <= op_we_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
    end
  end

  // Read data comes straight from the RAM's held dout while DONE; writes return zero.
  always_comb begin
    bus.a_ack    = (state_q == StDone) && (sel_q == PORT_A);
    bus.b_ack    = (state_q == StDone) && (sel_q == PORT_B);
    bus.a_rdata  = (bus.a_ack && !op_we_q) ? bus.ram_dout : '0;
    bus.b_rdata  = (bus.b_ack && !op_we_q) ? bus.ram_dout : '0;
    bus.ram_we   = ram_we_q;
    bus.ram_addr = ram_addr_q;
    bus.ram_din  = ram_din_q;
    bus.busy     = (state_q != StIdle);
  end

endmodule
